// File: rtl/fp64_pkg.sv
// Shared binary64 constants, field layout and sequencer states for the FP_Sub datapath.
// The round/pack helper and the subtractor top both import this package.
package fp64_pkg;

    localparam int          EXP_BIAS = 1023;
    localparam logic [10:0] EXP_MAX  = 11'h7FF;
    localparam logic [63:0] QNAN     = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] POS_INF  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] NEG_INF  = 64'hFFF0_0000_0000_0000;

    // Working mantissa is {hidden, 52 frac, G, R, S}; exponent carries one spare bit for overflow.
    localparam int MANT_W = 56;
    localparam int EXP_W  = 12;

    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [51:0] frac;
    } fp64_t;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADDSUB,
        NORM,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/fp64_round_pack.sv
// Combinational round-to-nearest-even and binary64 packing, including overflow to
// infinity and subnormal encoding. Shared by the FPU adder, subtractor and multiplier.
module fp64_round_pack
    import fp64_pkg::*;
(
    input  logic              i_sign,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [MANT_W-1:0] i_mant,
    output logic [63:0]       o_result,
    output logic              o_of,
    output logic              o_nx
);

    logic             w_lsb;
    logic             w_g;
    logic             w_r;
    logic             w_s;
    logic             w_inc;
    logic [53:0]      w_rounded;
    logic [EXP_W-1:0] w_exp;
    logic [51:0]      w_frac;

    assign w_lsb     = i_mant[3];
    assign w_g       = i_mant[2];
    assign w_r       = i_mant[1];
    assign w_s       = i_mant[0];
    assign w_inc     = w_g & (w_r | w_s | w_lsb);
    assign w_rounded = {1'b0, i_mant[55:3]} + {53'b0, w_inc};

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_exp    = '0;
        w_frac   = '0;
        o_result = '0;
        o_of     = 1'b0;
        o_nx     = w_g | w_r | w_s;

        // A subnormal input that rounds up into the hidden bit becomes the smallest normal.
        if (w_rounded[53]) begin
            w_exp  = i_exp + 12'd1;
            w_frac = w_rounded[52:1];
        end else if (w_rounded[52]) begin
            w_exp  = i_exp;
            w_frac = w_rounded[51:0];
        end else begin
            w_exp  = '0;
            w_frac = w_rounded[51:0];
        end

        if (w_exp >= {1'b0, EXP_MAX}) begin
            o_result = i_sign ? NEG_INF : POS_INF;
            o_of     = 1'b1;
            o_nx     = 1'b1;
        end else begin
            o_result = {i_sign, w_exp[10:0], w_frac};
        end
    end

endmodule

// File: rtl/fp64_sub_seq.sv
// Multi-cycle binary64 subtractor (a - b) with valid/ready handshakes on both sides.
// Unpack, align, add/sub, normalize, round and pack are sequenced by a small FSM.
module fp64_sub_seq
    import fp64_pkg::*;
#(
    parameter int ALIGN_STEP = 8,
    parameter int NORM_STEP  = 1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out,
    output logic        flag_nv,
    output logic        flag_of,
    output logic        flag_nx
);

    localparam logic [EXP_W-1:0] ALIGN_STEP_W = EXP_W'(ALIGN_STEP);

    state_t            r_state;
    state_t            w_state_next;
    fp64_t             r_a;
    fp64_t             r_b;
    logic              r_sign_x;
    logic              r_sign_y;
    logic [EXP_W-1:0]  r_exp;
    logic [MANT_W:0]   r_mx;
    logic [MANT_W-1:0] r_my;
    logic [EXP_W-1:0]  r_d;
    logic [63:0]       r_out;
    logic              r_nv;
    logic              r_of;
    logic              r_nx;

    // Operand classification and magnitude ordering, consumed in UNPACK.
    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_snan;
    logic              w_inf_clash, w_special;
    logic [63:0]       w_special_res;
    logic              w_swap;
    fp64_t             w_big, w_small;
    logic [EXP_W-1:0]  w_ex, w_ey, w_d_init;
    logic [MANT_W-1:0] w_mant_x, w_mant_y;

    assign w_a_nan     = (r_a.exp == EXP_MAX) && (r_a.frac != '0);
    assign w_b_nan     = (r_b.exp == EXP_MAX) && (r_b.frac != '0);
    assign w_a_inf     = (r_a.exp == EXP_MAX) && (r_a.frac == '0);
    assign w_b_inf     = (r_b.exp == EXP_MAX) && (r_b.frac == '0);
    assign w_snan      = (w_a_nan && !r_a.frac[51]) || (w_b_nan && !r_b.frac[51]);
    assign w_inf_clash = w_a_inf && w_b_inf && (r_a.sign != r_b.sign);
    assign w_special   = w_a_nan || w_b_nan || w_a_inf || w_b_inf;
    assign w_special_res = (w_a_nan || w_b_nan || w_inf_clash) ? QNAN :
                           w_a_inf ? 64'(r_a) : 64'(r_b);

    assign w_swap   = {r_b.exp, r_b.frac} > {r_a.exp, r_a.frac};
    assign w_big    = w_swap ? r_b : r_a;
    assign w_small  = w_swap ? r_a : r_b;
    assign w_ex     = (w_big.exp == '0)   ? 12'd1 : {1'b0, w_big.exp};
    assign w_ey     = (w_small.exp == '0) ? 12'd1 : {1'b0, w_small.exp};
    assign w_d_init = w_ex - w_ey;
    assign w_mant_x = {(w_big.exp != '0),   w_big.frac,   3'b000};
    assign w_mant_y = {(w_small.exp != '0), w_small.frac, 3'b000};

    // Alignment step: bounded right shift with sticky collection.
    logic [EXP_W-1:0]  w_align_sh;
    logic [MANT_W-1:0] w_align_mask;
    logic [MANT_W-1:0] w_my_next;
    logic [EXP_W-1:0]  w_d_next;

    assign w_align_sh   = (r_d > ALIGN_STEP_W) ? ALIGN_STEP_W : r_d;
    assign w_align_mask = ~({MANT_W{1'b1}} << w_align_sh);

    always_comb begin
        w_my_next = r_my;
        w_d_next  = r_d;
        if (r_d >= 12'd56) begin
            w_my_next = {55'b0, |r_my};
            w_d_next  = '0;
        end else begin
            w_my_next = (r_my >> w_align_sh) | {55'b0, |(r_my & w_align_mask)};
            w_d_next  = r_d - w_align_sh;
        end
    end

    // Normalization step: leading zeros capped at NORM_STEP and at the subnormal floor.
    logic [EXP_W-1:0] w_lz;
    logic             w_lz_found;
    logic [EXP_W-1:0] w_exp_room;
    logic [EXP_W-1:0] w_nshift;
    logic             w_norm_zero;
    logic             w_norm_stop;

    always_comb begin
        w_lz       = '0;
        w_lz_found = 1'b0;
        for (int i = 0; i < NORM_STEP; i++) begin
            if (!w_lz_found && !r_mx[55 - i]) begin
                w_lz = EXP_W'(i + 1);
            end else begin
                w_lz_found = 1'b1;
            end
        end
    end

    assign w_exp_room  = r_exp - 12'd1;
    assign w_nshift    = (w_lz > w_exp_room) ? w_exp_room : w_lz;
    assign w_norm_zero = (r_mx == '0);
    assign w_norm_stop = r_mx[55] || (r_exp == 12'd1);

    logic [63:0] w_round_res;
    logic        w_round_of;
    logic        w_round_nx;

    fp64_round_pack u_round_pack (
        .i_sign   (r_sign_x),
        .i_exp    (r_exp),
        .i_mant   (r_mx[MANT_W-1:0]),
        .o_result (w_round_res),
        .o_of     (w_round_of),
        .o_nx     (w_round_nx)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = UNPACK;
            UNPACK:  w_state_next = w_special ? DONE : ((w_d_init == '0) ? ADDSUB : ALIGN);
            ALIGN:   if (w_d_next == '0) w_state_next = ADDSUB;
            ADDSUB:  w_state_next = NORM;
            NORM: begin
                if (r_mx[56])         w_state_next = ROUND;
                else if (w_norm_zero) w_state_next = DONE;
                else if (w_norm_stop) w_state_next = ROUND;
            end
            ROUND:   w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: only the visible result and flags are reset; working registers are always loaded before use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= '0;
            r_nv  <= 1'b0;
            r_of  <= 1'b0;
            r_nx  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a  <= a;
                        r_b  <= {~b[63], b[62:0]};
                        r_nv <= 1'b0;
                        r_of <= 1'b0;
                        r_nx <= 1'b0;
                    end
                end
                UNPACK: begin
                    if (w_special) begin
                        r_out <= w_special_res;
                        r_nv  <= w_snan || w_inf_clash;
                    end else begin
                        r_sign_x <= w_big.sign;
                        r_sign_y <= w_small.sign;
                        r_exp    <= w_ex;
                        r_mx     <= {1'b0, w_mant_x};
                        r_my     <= w_mant_y;
                        r_d      <= w_d_init;
                    end
                end
                ALIGN: begin
                    r_my <= w_my_next;
                    r_d  <= w_d_next;
                end
                ADDSUB: begin
                    if (r_sign_x == r_sign_y) begin
                        r_mx <= {1'b0, r_mx[MANT_W-1:0]} + {1'b0, r_my};
                    end else begin
                        r_mx <= {1'b0, r_mx[MANT_W-1:0]} - {1'b0, r_my};
                    end
                end
                NORM: begin
                    if (r_mx[56]) begin
                        r_mx  <= {1'b0, r_mx[56:2], r_mx[1] | r_mx[0]};
                        r_exp <= r_exp + 12'd1;
                    end else if (w_norm_zero) begin
                        // Exact cancellation is +0 unless both addends were negative.
                        r_out <= {r_sign_x & r_sign_y, 63'b0};
                    end else if (!w_norm_stop) begin
                        r_mx  <= r_mx << w_nshift;
                        r_exp <= r_exp - w_nshift;
                    end
                end
                ROUND: begin
                    r_out <= w_round_res;
                    r_of  <= w_round_of;
                    r_nx  <= w_round_nx;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out       = r_out;
    assign flag_nv   = r_nv;
    assign flag_of   = r_of;
    assign flag_nx   = r_nx;

endmodule

// File: tb/tb_fp64_sub_seq.sv
// Directed bench for fp64_sub_seq: hand-computed binary64 differences, flags,
// output back-pressure and reset abort in the middle of normalization.
module tb_fp64_sub_seq;

    localparam int TIMEOUT = 300;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out;
    logic        flag_nv;
    logic        flag_of;
    logic        flag_nx;

    int n_checks = 0;
    int n_fail   = 0;

    fp64_sub_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flag_nv   (flag_nv),
        .flag_of   (flag_of),
        .flag_nx   (flag_nx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Flags compared as {nv, of, nx}.
    task automatic run_op(input string tag, input logic [63:0] op_a, input logic [63:0] op_b,
                          input logic [63:0] exp_out, input logic [2:0] exp_flags,
                          input int n_stall);
        int   cyc;
        logic seen;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < TIMEOUT && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_done"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_out"}, out, exp_out);
            check({tag, "_flags"}, 64'({flag_nv, flag_of, flag_nx}), 64'(exp_flags));
            for (int i = 0; i < n_stall; i++) begin
                @(negedge clk);
                check({tag, "_hold_out"}, out, exp_out);
                check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
                check({tag, "_hold_inrdy"}, 64'(in_ready), 64'd0);
                check({tag, "_hold_flags"}, 64'({flag_nv, flag_of, flag_nx}), 64'(exp_flags));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, "_inrdy_after"}, 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        int stale;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out", out, 64'd0);
        check("reset_flags", 64'({flag_nv, flag_of, flag_nx}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("three_minus_one", 64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 3'b000, 0);
        run_op("one_minus_prev",  64'h3FF0000000000000, 64'h3FEFFFFFFFFFFFFF, 64'h3CA0000000000000, 3'b000, 0);
        run_op("one_minus_2m60",  64'h3FF0000000000000, 64'h3C30000000000000, 64'h3FF0000000000000, 3'b001, 0);
        run_op("one_minus_three", 64'h3FF0000000000000, 64'h4008000000000000, 64'hC000000000000000, 3'b000, 0);
        run_op("one_minus_one",   64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 3'b000, 0);
        run_op("negz_minus_posz", 64'h8000000000000000, 64'h0000000000000000, 64'h8000000000000000, 3'b000, 0);
        run_op("inf_minus_inf",   64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 3'b100, 0);
        run_op("inf_minus_one",   64'h7FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000, 3'b000, 0);
        run_op("snan_operand",    64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 3'b100, 0);
        run_op("qnan_operand",    64'h3FF0000000000000, 64'h7FF8000000000001, 64'h7FF8000000000000, 3'b000, 0);
        run_op("overflow",        64'h7FEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF, 64'h7FF0000000000000, 3'b011, 0);
        run_op("subnormal_diff",  64'h0000000000000002, 64'h0000000000000001, 64'h0000000000000001, 3'b000, 0);
        run_op("minnorm_minus_d", 64'h0010000000000000, 64'h0000000000000001, 64'h000FFFFFFFFFFFFF, 3'b000, 0);
        run_op("stall",           64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 3'b000, 10);

        // Abort a long normalization with reset; no result may appear afterwards.
        a        = 64'h3FF0000000000000;
        b        = 64'h3FEFFFFFFFFFFFFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out", out, 64'd0);
        stale = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("abort_no_stale", 64'(stale), 64'd0);

        run_op("after_abort", 64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 3'b000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
